// File: rtl/cpu_core.sv
// cpu_core: multicycle 16-bit THCO MIPS16e subset core driving board SRAMs and UART
module cpu_core #(
    parameter int          DATA_W    = 16,
    parameter int          ADDR_W    = 18,
    parameter logic [15:0] UART_DATA = 16'hBF00,
    parameter logic [15:0] UART_STAT = 16'hBF01
) (
    input  logic              clk,
    input  logic              rst,
    inout  wire  [DATA_W-1:0] ram1_data,
    output logic [ADDR_W-1:0] ram1_addr,
    output logic              ram1_en,
    output logic              ram1_oe,
    output logic              ram1_we,
    inout  wire  [DATA_W-1:0] ram2_data,
    output logic [ADDR_W-1:0] ram2_addr,
    output logic              ram2_en,
    output logic              ram2_oe,
    output logic              ram2_we,
    input  logic              tsre,
    input  logic              tbre,
    input  logic              data_ready,
    output logic              rdn,
    output logic              wrn
);
    typedef enum logic [2:0] {S_FETCH, S_EXEC, S_MEM_R, S_MEM_W1, S_MEM_W2} state_t;

    state_t            r_state, w_next;
    logic [DATA_W-1:0] r_pc, r_ir, r_ea, r_wdata;
    logic [DATA_W-1:0] r_regs [8];
    logic [4:0]        w_op;
    logic [2:0]        w_rx, w_ry, w_rz;
    logic [DATA_W-1:0] w_vx, w_vy, w_sext8, w_sext5, w_sext11, w_load;
    logic              w_stat, w_udata, w_drive;

    assign w_op     = r_ir[15:11];
    assign w_rx     = r_ir[10:8];
    assign w_ry     = r_ir[7:5];
    assign w_rz     = r_ir[4:2];
    assign w_vx     = r_regs[w_rx];
    assign w_vy     = r_regs[w_ry];
    assign w_sext8  = {{(DATA_W-8){r_ir[7]}}, r_ir[7:0]};
    assign w_sext5  = {{(DATA_W-5){r_ir[4]}}, r_ir[4:0]};
    assign w_sext11 = {{(DATA_W-11){r_ir[10]}}, r_ir[10:0]};
    assign w_stat   = r_ea == UART_STAT;
    assign w_udata  = r_ea == UART_DATA;
    assign w_load   = w_stat ? {{(DATA_W-2){1'b0}}, data_ready, tsre & tbre}
                    : w_udata ? {{(DATA_W-8){1'b0}}, ram1_data[7:0]} : ram1_data;
    assign ram1_data = w_drive ? r_wdata : {DATA_W{1'bz}};

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_FETCH;
        else      r_state <= w_next;
    end

    // Next state plus bus controls; reset forces every strobe idle without waiting for a clock
    always_comb begin
        w_next    = r_state;
        ram1_addr = '0;
        ram2_addr = '0;
        {ram1_en, ram1_oe, ram1_we, ram2_en, ram2_oe, ram2_we, rdn, wrn, w_drive} = 9'b111111110;
        case (r_state)
            S_FETCH: begin
                w_next    = S_EXEC;
                ram2_addr = {{(ADDR_W-DATA_W){1'b0}}, r_pc};
                {ram2_en, ram2_oe} = 2'b00;
            end
            S_EXEC: w_next = w_op == 5'b10011 ? S_MEM_R : w_op == 5'b11011 ? S_MEM_W1 : S_FETCH;
            S_MEM_R: begin
                w_next = S_FETCH;
                if (w_udata) rdn = 1'b0;
                else if (!w_stat) begin
                    ram1_addr          = {{(ADDR_W-DATA_W){1'b0}}, r_ea};
                    {ram1_en, ram1_oe} = 2'b00;
                end
            end
            S_MEM_W1, S_MEM_W2: begin
                w_next  = r_state == S_MEM_W1 ? S_MEM_W2 : S_FETCH;
                w_drive = !w_stat;
                if (w_udata) wrn = r_state != S_MEM_W1;
                else if (!w_stat) begin
                    ram1_addr = {{(ADDR_W-DATA_W){1'b0}}, r_ea};
                    ram1_en   = 1'b0;
                    ram1_we   = r_state != S_MEM_W1;
                end
            end
            default: w_next = S_FETCH;
        endcase
        if (!rst) begin
            ram1_addr = '0;
            ram2_addr = '0;
            {ram1_en, ram1_oe, ram1_we, ram2_en, ram2_oe, ram2_we, rdn, wrn, w_drive} = 9'b111111110;
        end
    end

    // Datapath: fetch latch, instruction execute, load write-back
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc    <= '0;
            r_ir    <= '0;
            r_ea    <= '0;
            r_wdata <= '0;
            for (int i = 0; i < 8; i++) r_regs[i] <= '0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    r_ir <= ram2_data;
                    r_pc <= r_pc + 1'b1;
                end
                S_EXEC: begin
                    case (w_op)
                        5'b01001: r_regs[w_rx] <= w_vx + w_sext8;
                        5'b01101: r_regs[w_rx] <= {{(DATA_W-8){1'b0}}, r_ir[7:0]};
                        5'b11100: begin
                            if (r_ir[1:0] == 2'b01)      r_regs[w_rz] <= w_vx + w_vy;
                            else if (r_ir[1:0] == 2'b11) r_regs[w_rz] <= w_vx - w_vy;
                        end
                        5'b11101: begin
                            if (r_ir[4:0] == 5'b01100)      r_regs[w_rx] <= w_vx & w_vy;
                            else if (r_ir[4:0] == 5'b01101) r_regs[w_rx] <= w_vx | w_vy;
                            else if (r_ir[7:0] == 8'h00)    r_pc <= w_vx;
                        end
                        5'b00010: r_pc <= r_pc + w_sext11;
                        5'b00100: if (w_vx == '0) r_pc <= r_pc + w_sext8;
                        5'b00101: if (w_vx != '0) r_pc <= r_pc + w_sext8;
                        5'b10011: r_ea <= w_vx + w_sext5;
                        5'b11011: begin
                            r_ea    <= w_vx + w_sext5;
                            r_wdata <= w_vy;
                        end
                        default: ;
                    endcase
                end
                S_MEM_R: r_regs[w_ry] <= w_load;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: instruction-level model drives per-cycle pin expectations for cpu_core
module tb_cpu_core;
    localparam logic [2:0] T_NONE = 3'd0, T_F = 3'd1, T_X = 3'd2, T_R = 3'd3, T_W1 = 3'd4, T_W2 = 3'd5;

    typedef struct packed {
        logic [2:0]  tag;
        logic [17:0] r2a;
        logic [2:0]  r2c;
        logic [17:0] r1a;
        logic [2:0]  r1c;
        logic        rdn;
        logic        wrn;
        logic        drv;
        logic [15:0] dat;
    } rec_t;

    logic        clk = 1'b0, rst = 1'b0, run = 1'b0;
    logic        tsre = 1'b1, tbre = 1'b1, data_ready = 1'b1;
    wire  [15:0] ram1_data, ram2_data;
    logic [17:0] ram1_addr, ram2_addr;
    logic        ram1_en, ram1_oe, ram1_we, ram2_en, ram2_oe, ram2_we, rdn, wrn;
    logic [15:0] imem [256];
    logic [15:0] sram [256] = '{default: 16'h0000};
    logic [15:0] m_mem [256] = '{default: 16'h0000};
    logic [15:0] uart_rx = 16'hA5C3;
    logic [15:0] m_pc;
    logic [15:0] m_r [8];
    rec_t        q [$];
    logic [2:0]  cur_tag = T_NONE;
    logic [15:0] cur_fetch = 16'hFFFF;
    logic [7:0]  tx_byte = 8'h00;
    int          wrn_cnt = 0, we_cnt = 0;
    int          c_pass = 0, c_fail = 0, t_pass = 0, t_fail = 0;

    always #5 clk = ~clk;

    cpu_core dut (
        .clk(clk), .rst(rst),
        .ram1_data(ram1_data), .ram1_addr(ram1_addr), .ram1_en(ram1_en), .ram1_oe(ram1_oe), .ram1_we(ram1_we),
        .ram2_data(ram2_data), .ram2_addr(ram2_addr), .ram2_en(ram2_en), .ram2_oe(ram2_oe), .ram2_we(ram2_we),
        .tsre(tsre), .tbre(tbre), .data_ready(data_ready), .rdn(rdn), .wrn(wrn)
    );

    assign ram2_data = imem[ram2_addr[7:0]];
    assign ram1_data = (!ram1_en && !ram1_oe && ram1_we) ? sram[ram1_addr[7:0]] : (!rdn ? uart_rx : 16'hzzzz);

    // Board SRAM and UART transmitter emulation
    always @(negedge clk) begin
        if (!ram1_en && !ram1_we) begin
            sram[ram1_addr[7:0]] <= ram1_data;
            we_cnt <= we_cnt + 1;
        end
        if (!wrn) begin
            tx_byte <= ram1_data[7:0];
            wrn_cnt <= wrn_cnt + 1;
        end
    end

    function automatic logic [15:0] i8(input logic [4:0] op, input logic [2:0] rx, input logic [7:0] imm);
        return {op, rx, imm};
    endfunction
    function automatic logic [15:0] i5(input logic [4:0] op, input logic [2:0] rx, input logic [2:0] ry, input logic [4:0] imm);
        return {op, rx, ry, imm};
    endfunction

    function automatic rec_t idle(input logic [2:0] t);
        rec_t r;
        r = '0;
        r.tag = t;
        r.r2c = 3'b111;
        r.r1c = 3'b111;
        r.rdn = 1'b1;
        r.wrn = 1'b1;
        return r;
    endfunction

    // Execute one instruction on the architectural model and queue the pin pattern of each of its cycles
    task automatic model_step();
        logic [15:0] ir, ea, val, vx, vy;
        logic [2:0]  rx, ry, rz;
        rec_t        f, w1, w2;
        ir = imem[m_pc[7:0]];
        rx = ir[10:8];
        ry = ir[7:5];
        rz = ir[4:2];
        vx = m_r[rx];
        vy = m_r[ry];
        f = idle(T_F);
        f.r2a = {2'b00, m_pc};
        f.r2c = 3'b001;
        q.push_back(f);
        q.push_back(idle(T_X));
        m_pc = m_pc + 16'd1;
        ea = vx + 16'($signed(ir[4:0]));
        case (ir[15:11])
            5'b01001: m_r[rx] = vx + 16'($signed(ir[7:0]));
            5'b01101: m_r[rx] = {8'h00, ir[7:0]};
            5'b11100: if (ir[1:0] == 2'b01) m_r[rz] = vx + vy; else if (ir[1:0] == 2'b11) m_r[rz] = vx - vy;
            5'b11101: if (ir[4:0] == 5'b01100) m_r[rx] = vx & vy; else if (ir[4:0] == 5'b01101) m_r[rx] = vx | vy;
                      else if (ir[7:0] == 8'h00) m_pc = vx;
            5'b00010: m_pc = m_pc + 16'($signed(ir[10:0]));
            5'b00100: if (vx == 16'h0) m_pc = m_pc + 16'($signed(ir[7:0]));
            5'b00101: if (vx != 16'h0) m_pc = m_pc + 16'($signed(ir[7:0]));
            5'b10011: begin
                f = idle(T_R);
                if (ea == 16'hBF01) val = {14'h0, data_ready, tsre & tbre};
                else if (ea == 16'hBF00) begin
                    f.rdn = 1'b0;
                    val = {8'h00, uart_rx[7:0]};
                end else begin
                    f.r1a = {2'b00, ea};
                    f.r1c = 3'b001;
                    val = m_mem[ea[7:0]];
                end
                q.push_back(f);
                m_r[ry] = val;
            end
            5'b11011: begin
                w1 = idle(T_W1);
                w2 = idle(T_W2);
                if (ea != 16'hBF01) begin
                    w1.drv = 1'b1; w1.dat = vy;
                    w2.drv = 1'b1; w2.dat = vy;
                    if (ea == 16'hBF00) w1.wrn = 1'b0;
                    else begin
                        w1.r1a = {2'b00, ea}; w1.r1c = 3'b010;
                        w2.r1a = {2'b00, ea}; w2.r1c = 3'b011;
                        m_mem[ea[7:0]] = vy;
                    end
                end
                q.push_back(w1);
                q.push_back(w2);
            end
            default: ;
        endcase
    endtask

    // Per-cycle compare of every bus pin against the model's queued expectations
    initial forever begin
        rec_t e;
        @(negedge clk);
        if (!rst) begin
            q.delete();
            m_pc = 16'h0;
            for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
            cur_tag = T_NONE;
            cur_fetch = 16'hFFFF;
        end else if (run) begin
            if (q.size() == 0) model_step();
            e = q.pop_front();
            cur_tag = e.tag;
            if (e.tag == T_F) cur_fetch = e.r2a[15:0];
            if ({ram2_addr, ram2_en, ram2_oe, ram2_we, ram1_addr, ram1_en, ram1_oe, ram1_we, rdn, wrn} !=
                {e.r2a, e.r2c, e.r1a, e.r1c, e.rdn, e.wrn} || (e.drv && ram1_data != e.dat)) begin
                c_fail++;
                $display("FAIL pins tag=%0d got r2a=%h r2c=%b r1a=%h r1c=%b rdn=%b wrn=%b d=%h exp r2a=%h r2c=%b r1a=%h r1c=%b rdn=%b wrn=%b d=%h(drv=%b)",
                         e.tag, ram2_addr, {ram2_en, ram2_oe, ram2_we}, ram1_addr, {ram1_en, ram1_oe, ram1_we}, rdn, wrn, ram1_data,
                         e.r2a, e.r2c, e.r1a, e.r1c, e.rdn, e.wrn, e.dat, e.drv);
            end else c_pass++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            t_fail++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end else t_pass++;
    endtask

    task automatic release_rst();
        @(posedge clk);
        #1;
        rst = 1'b1;
        run = 1'b1;
    endtask

    task automatic wait_fetch(input logic [15:0] pc);
        int n;
        n = 0;
        while (cur_fetch != pc && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (cur_fetch != pc) begin
            t_fail++;
            $display("FAIL timeout waiting for fetch of %h", pc);
        end
    endtask

    initial begin
        int n;
        for (int i = 0; i < 256; i++) imem[i] = 16'h0800;
        imem[0]  = i8(5'b01101, 3'd1, 8'h05);
        imem[1]  = i8(5'b01001, 3'd1, 8'hFF);
        imem[2]  = i8(5'b00101, 3'd1, 8'hFE);
        imem[3]  = i8(5'b01101, 3'd2, 8'h80);
        imem[4]  = i8(5'b01101, 3'd3, 8'h34);
        imem[5]  = i5(5'b11011, 3'd2, 3'd3, 5'd1);
        imem[6]  = i5(5'b10011, 3'd2, 3'd4, 5'd1);
        imem[7]  = i5(5'b11011, 3'd2, 3'd4, 5'd2);
        imem[8]  = i8(5'b01101, 3'd5, 8'hBF);
        for (int i = 9; i <= 16; i++) imem[i] = {5'b11100, 3'd5, 3'd5, 3'd5, 2'b01};
        imem[17] = i8(5'b01101, 3'd3, 8'h41);
        imem[18] = i5(5'b11011, 3'd5, 3'd3, 5'd0);
        imem[19] = i5(5'b10011, 3'd5, 3'd6, 5'd1);
        imem[20] = i5(5'b11011, 3'd2, 3'd6, 5'd3);
        imem[21] = i5(5'b10011, 3'd5, 3'd7, 5'd0);
        imem[22] = i5(5'b11011, 3'd2, 3'd7, 5'd4);
        imem[23] = {5'b11100, 3'd1, 3'd4, 3'd0, 2'b11};
        imem[24] = {5'b11101, 3'd0, 3'd4, 5'b01100};
        imem[25] = {5'b11101, 3'd0, 3'd3, 5'b01101};
        imem[26] = i5(5'b11011, 3'd2, 3'd0, 5'd5);
        imem[27] = i8(5'b00100, 3'd1, 8'h01);
        imem[28] = i8(5'b01101, 3'd0, 8'hEE);
        imem[29] = {5'b00010, 11'h001};
        imem[30] = i8(5'b01101, 3'd0, 8'hDD);
        imem[31] = i8(5'b01101, 3'd1, 8'h28);
        imem[32] = {5'b11101, 3'd1, 8'h00};
        imem[40] = i5(5'b11011, 3'd2, 3'd0, 5'd6);
        imem[41] = {5'b00010, 11'h7FF};

        repeat (3) @(negedge clk);
        check("reset_strobes", {24'h0, ram1_en, ram1_oe, ram1_we, ram2_en, ram2_oe, ram2_we, rdn, wrn}, 32'hFF);
        check("reset_ram1_addr", {14'h0, ram1_addr}, 32'h0);
        check("reset_ram2_addr", {14'h0, ram2_addr}, 32'h0);

        release_rst();
        wait_fetch(16'd41);
        repeat (6) @(negedge clk);
        check("sw_ram_0x81", {16'h0, sram[8'h81]}, 32'h0034);
        check("lw_r4_0x82", {16'h0, sram[8'h82]}, 32'h0034);
        check("uart_stat_3", {16'h0, sram[8'h83]}, 32'h0003);
        check("uart_rx_0x84", {16'h0, sram[8'h84]}, 32'h00C3);
        check("subu_and_or", {16'h0, sram[8'h85]}, 32'h0045);
        check("branch_skips", {16'h0, sram[8'h86]}, 32'h0045);
        check("uart_tx_byte", {24'h0, tx_byte}, 32'h41);
        check("wrn_low_cycles", wrn_cnt, 32'd1);
        check("we_low_cycles", we_cnt, 32'd6);

        rst = 1'b0;
        run = 1'b0;
        repeat (2) @(negedge clk);
        release_rst();
        n = 0;
        while (cur_tag != T_W1 && n < 500) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("reached_mem_w1", {29'h0, cur_tag}, {29'h0, T_W1});
        check("w1_we_low", {31'h0, ram1_we}, 32'h0);
        rst = 1'b0;
        run = 1'b0;
        #1;
        check("abort_strobes", {29'h0, ram1_we, wrn, ram1_en}, 32'h7);
        check("abort_ram1_addr", {14'h0, ram1_addr}, 32'h0);
        tbre = 1'b0;
        data_ready = 1'b0;
        repeat (2) @(negedge clk);
        release_rst();
        @(negedge clk);
        #1;
        check("pc_zero_after_abort", {14'h0, ram2_addr, ram2_en}, 32'h0);
        wait_fetch(16'd41);
        repeat (6) @(negedge clk);
        check("uart_stat_0", {16'h0, sram[8'h83]}, 32'h0000);
        check("rerun_0x86", {16'h0, sram[8'h86]}, 32'h0045);
        run = 1'b0;
        $display("%0d/%0d checks passed", c_pass + t_pass, c_pass + c_fail + t_pass + t_fail);
        $finish;
    end
endmodule
